// File: rtl/i2c_arbiter_if.sv
// Command plus write-data stream bundle shared by the i2c_master host port
// and each requester of the arbiter.
interface i2c_arbiter_if;
    logic [6:0] cmd_address;
    logic       cmd_start;
    logic       cmd_read;
    logic       cmd_write;
    logic       cmd_write_multiple;
    logic       cmd_stop;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       data_last;

    modport master (
        output cmd_address,
        output cmd_start,
        output cmd_read,
        output cmd_write,
        output cmd_write_multiple,
        output cmd_stop,
        output cmd_valid,
        input  cmd_ready,
        output data,
        output data_valid,
        input  data_ready,
        output data_last
    );

    modport slave (
        input  cmd_address,
        input  cmd_start,
        input  cmd_read,
        input  cmd_write,
        input  cmd_write_multiple,
        input  cmd_stop,
        input  cmd_valid,
        output cmd_ready,
        input  data,
        input  data_valid,
        output data_ready,
        input  data_last
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Two-requester arbiter for one i2c_master host port; a grant is held for a
// whole I2C transaction and can be reclaimed from a stalled owner by timeout.
module i2c_arbiter #(
    parameter int ROUND_ROBIN = 0,
    parameter int TIMEOUT     = 0
) (
    input  logic          clk,
    input  logic          rst,
    i2c_arbiter_if.slave  r0,
    i2c_arbiter_if.slave  r1,
    i2c_arbiter_if.master m,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          timeout
);

    localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] CMAX  = '1;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    grant_next;
    logic          last_owner;
    logic          last_owner_next;
    logic          wm_stop;
    logic          wm_stop_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_inc;
    logic          timeout_next;

    logic [6:0]    sel_address;
    logic          sel_start;
    logic          sel_read;
    logic          sel_write;
    logic          sel_write_multiple;
    logic          sel_stop;
    logic          sel_cmd_valid;
    logic [7:0]    sel_data;
    logic          sel_data_valid;
    logic          sel_data_last;

    logic          cmd_fire;
    logic          data_fire;
    logic          eot;
    logic          owner_active;
    logic          expire;

    // Owner mux; everything reads 0 toward the master while nobody owns the bus.
    always_comb begin
        sel_address        = '0;
        sel_start          = 1'b0;
        sel_read           = 1'b0;
        sel_write          = 1'b0;
        sel_write_multiple = 1'b0;
        sel_stop           = 1'b0;
        sel_cmd_valid      = 1'b0;
        sel_data           = '0;
        sel_data_valid     = 1'b0;
        sel_data_last      = 1'b0;
        if (grant[0]) begin
            sel_address        = r0.cmd_address;
            sel_start          = r0.cmd_start;
            sel_read           = r0.cmd_read;
            sel_write          = r0.cmd_write;
            sel_write_multiple = r0.cmd_write_multiple;
            sel_stop           = r0.cmd_stop;
            sel_cmd_valid      = r0.cmd_valid;
            sel_data           = r0.data;
            sel_data_valid     = r0.data_valid;
            sel_data_last      = r0.data_last;
        end else if (grant[1]) begin
            sel_address        = r1.cmd_address;
            sel_start          = r1.cmd_start;
            sel_read           = r1.cmd_read;
            sel_write          = r1.cmd_write;
            sel_write_multiple = r1.cmd_write_multiple;
            sel_stop           = r1.cmd_stop;
            sel_cmd_valid      = r1.cmd_valid;
            sel_data           = r1.data;
            sel_data_valid     = r1.data_valid;
            sel_data_last      = r1.data_last;
        end
    end

    assign m.cmd_address        = sel_address;
    assign m.cmd_start          = sel_start;
    assign m.cmd_read           = sel_read;
    assign m.cmd_write          = sel_write;
    assign m.cmd_write_multiple = sel_write_multiple;
    assign m.cmd_stop           = sel_stop;
    assign m.cmd_valid          = sel_cmd_valid;
    assign m.data               = sel_data;
    assign m.data_valid         = sel_data_valid;
    assign m.data_last          = sel_data_last;

    assign r0.cmd_ready  = grant[0] & m.cmd_ready;
    assign r0.data_ready = grant[0] & m.data_ready;
    assign r1.cmd_ready  = grant[1] & m.cmd_ready;
    assign r1.data_ready = grant[1] & m.data_ready;

    assign busy = (state == OWN);

    // A write_multiple+stop defers the end of transaction to the last data beat.
    assign cmd_fire     = sel_cmd_valid & m.cmd_ready;
    assign data_fire    = sel_data_valid & m.data_ready;
    assign eot          = (cmd_fire & sel_stop & ~sel_write_multiple)
                        | (data_fire & sel_data_last & wm_stop);
    assign owner_active = sel_cmd_valid | sel_data_valid;
    assign count_inc    = (count == CMAX) ? count : count + CW'(1);
    assign expire       = (TIMEOUT > 0) && (state == OWN) && !owner_active
                          && (count_inc == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b1;
            wm_stop    <= 1'b0;
            count      <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_owner <= last_owner_next;
            wm_stop    <= wm_stop_next;
            count      <= count_next;
            timeout    <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_owner_next = last_owner;
        wm_stop_next    = wm_stop;
        count_next      = count;
        timeout_next    = 1'b0;
        case (state)
            IDLE: begin
                count_next   = '0;
                wm_stop_next = 1'b0;
                grant_next   = 2'b00;
                if (r0.cmd_valid || r1.cmd_valid) begin
                    state_next = OWN;
                    if ((ROUND_ROBIN != 0) && r0.cmd_valid && r1.cmd_valid) begin
                        grant_next = last_owner ? 2'b01 : 2'b10;
                    end else if (r0.cmd_valid) begin
                        grant_next = 2'b01;
                    end else begin
                        grant_next = 2'b10;
                    end
                end
            end
            OWN: begin
                if (eot || expire) begin
                    state_next      = IDLE;
                    grant_next      = 2'b00;
                    last_owner_next = grant[1];
                    wm_stop_next    = 1'b0;
                    count_next      = '0;
                    timeout_next    = expire;
                end else begin
                    if (cmd_fire && sel_write_multiple && sel_stop) begin
                        wm_stop_next = 1'b1;
                    end
                    count_next = owner_active ? '0 : count_inc;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: a fixed-priority instance with an 8-cycle
// timeout and a round-robin instance without timeout.
module tb_i2c_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0] f_grant;
    logic       f_busy;
    logic       f_timeout;
    logic [1:0] q_grant;
    logic       q_busy;
    logic       q_timeout;

    i2c_arbiter_if f_r0 ();
    i2c_arbiter_if f_r1 ();
    i2c_arbiter_if f_m ();
    i2c_arbiter_if q_r0 ();
    i2c_arbiter_if q_r1 ();
    i2c_arbiter_if q_m ();

    i2c_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(8)) dut_fix (
        .clk(clk), .rst(rst), .r0(f_r0), .r1(f_r1), .m(f_m),
        .grant(f_grant), .busy(f_busy), .timeout(f_timeout)
    );

    i2c_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(0)) dut_rr (
        .clk(clk), .rst(rst), .r0(q_r0), .r1(q_r1), .m(q_m),
        .grant(q_grant), .busy(q_busy), .timeout(q_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] rr_exp [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
                      tag, observed, expected, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit req, input logic [6:0] addr,
                                 input logic start, input logic rd, input logic wr,
                                 input logic wm, input logic stop, input logic valid);
        if (!req) begin
            f_r0.cmd_address = addr; f_r0.cmd_start = start; f_r0.cmd_read = rd;
            f_r0.cmd_write = wr; f_r0.cmd_write_multiple = wm; f_r0.cmd_stop = stop;
            f_r0.cmd_valid = valid;
        end else begin
            f_r1.cmd_address = addr; f_r1.cmd_start = start; f_r1.cmd_read = rd;
            f_r1.cmd_write = wr; f_r1.cmd_write_multiple = wm; f_r1.cmd_stop = stop;
            f_r1.cmd_valid = valid;
        end
    endtask

    task automatic applyData(input bit req, input logic [7:0] d, input logic valid,
                             input logic last);
        if (!req) begin
            f_r0.data = d; f_r0.data_valid = valid; f_r0.data_last = last;
        end else begin
            f_r1.data = d; f_r1.data_valid = valid; f_r1.data_last = last;
        end
    endtask

    task automatic clearAll;
        applyStimulus(0, 7'h00, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 7'h00, 0, 0, 0, 0, 0, 0);
        applyData(0, 8'h00, 0, 0);
        applyData(1, 8'h00, 0, 0);
        f_m.cmd_ready = 1'b1; f_m.data_ready = 1'b1;
        q_r0.cmd_address = 7'h00; q_r0.cmd_start = 0; q_r0.cmd_read = 0; q_r0.cmd_write = 0;
        q_r0.cmd_write_multiple = 0; q_r0.cmd_stop = 0; q_r0.cmd_valid = 0;
        q_r0.data = 8'h00; q_r0.data_valid = 0; q_r0.data_last = 0;
        q_r1.cmd_address = 7'h00; q_r1.cmd_start = 0; q_r1.cmd_read = 0; q_r1.cmd_write = 0;
        q_r1.cmd_write_multiple = 0; q_r1.cmd_stop = 0; q_r1.cmd_valid = 0;
        q_r1.data = 8'h00; q_r1.data_valid = 0; q_r1.data_last = 0;
        q_m.cmd_ready = 1'b1; q_m.data_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clearAll();
        tick(); tick();
        #1;
        checkOutput("rst_grant", 32'(f_grant), 32'h0);
        checkOutput("rst_busy", 32'(f_busy), 32'h0);
        checkOutput("rst_timeout", 32'(f_timeout), 32'h0);
        checkOutput("rst_m_cmd_valid", 32'(f_m.cmd_valid), 32'h0);
        checkOutput("rst_m_data_valid", 32'(f_m.data_valid), 32'h0);
        checkOutput("rst_m_address", 32'(f_m.cmd_address), 32'h0);
        checkOutput("rst_r0_cmd_ready", 32'(f_r0.cmd_ready), 32'h0);
        checkOutput("rst_r1_data_ready", 32'(f_r1.data_ready), 32'h0);
        checkOutput("rst_rr_grant", 32'(q_grant), 32'h0);
        rst = 1'b0;

        // Single read, fixed mode
        tick();
        applyStimulus(0, 7'h6A, 1, 1, 0, 0, 0, 1);
        #1;
        checkOutput("rd_grant_pre", 32'(f_grant), 32'h0);
        checkOutput("rd_r0_ready_pre", 32'(f_r0.cmd_ready), 32'h0);
        tick(); #1;
        checkOutput("rd_grant", 32'(f_grant), 32'h1);
        checkOutput("rd_busy", 32'(f_busy), 32'h1);
        checkOutput("rd_m_cmd_valid", 32'(f_m.cmd_valid), 32'h1);
        checkOutput("rd_m_address", 32'(f_m.cmd_address), 32'h6A);
        checkOutput("rd_m_start", 32'(f_m.cmd_start), 32'h1);
        checkOutput("rd_r0_ready", 32'(f_r0.cmd_ready), 32'h1);
        tick();
        applyStimulus(0, 7'h6A, 0, 1, 0, 0, 1, 1);
        #1;
        checkOutput("rd2_m_stop", 32'(f_m.cmd_stop), 32'h1);
        checkOutput("rd2_m_start", 32'(f_m.cmd_start), 32'h0);
        checkOutput("rd2_grant", 32'(f_grant), 32'h1);
        tick();
        applyStimulus(0, 7'h6A, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rd_release_grant", 32'(f_grant), 32'h0);
        checkOutput("rd_release_busy", 32'(f_busy), 32'h0);
        checkOutput("rd_release_ready", 32'(f_r0.cmd_ready), 32'h0);

        // Fixed-priority tie, then write-multiple lock by r1
        tick();
        f_m.cmd_ready = 1'b0;
        applyStimulus(0, 7'h10, 1, 0, 1, 0, 1, 1);
        applyStimulus(1, 7'h41, 1, 0, 1, 1, 1, 1);
        #1;
        checkOutput("tie_grant_pre", 32'(f_grant), 32'h0);
        tick(); #1;
        checkOutput("tie_grant", 32'(f_grant), 32'h1);
        checkOutput("tie_r1_ready", 32'(f_r1.cmd_ready), 32'h0);
        checkOutput("tie_r0_ready_stall", 32'(f_r0.cmd_ready), 32'h0);
        tick();
        f_m.cmd_ready = 1'b1;
        #1;
        checkOutput("tie_hold_grant", 32'(f_grant), 32'h1);
        checkOutput("tie_r1_ready2", 32'(f_r1.cmd_ready), 32'h0);
        checkOutput("tie_r0_ready", 32'(f_r0.cmd_ready), 32'h1);
        tick();
        applyStimulus(0, 7'h10, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("tie_dead_grant", 32'(f_grant), 32'h0);
        checkOutput("tie_dead_r1_ready", 32'(f_r1.cmd_ready), 32'h0);
        tick();
        applyStimulus(0, 7'h22, 1, 0, 1, 0, 0, 1);
        #1;
        checkOutput("wm_grant", 32'(f_grant), 32'h2);
        checkOutput("wm_m_address", 32'(f_m.cmd_address), 32'h41);
        checkOutput("wm_m_wm", 32'(f_m.cmd_write_multiple), 32'h1);
        checkOutput("wm_r1_ready", 32'(f_r1.cmd_ready), 32'h1);
        checkOutput("wm_r0_ready", 32'(f_r0.cmd_ready), 32'h0);
        tick();
        applyStimulus(1, 7'h41, 0, 0, 0, 0, 0, 0);
        applyData(1, 8'h06, 1, 0);
        #1;
        checkOutput("wm_b0_grant", 32'(f_grant), 32'h2);
        checkOutput("wm_b0_data", 32'(f_m.data), 32'h06);
        checkOutput("wm_b0_valid", 32'(f_m.data_valid), 32'h1);
        checkOutput("wm_b0_m_cmd_valid", 32'(f_m.cmd_valid), 32'h0);
        checkOutput("wm_b0_r0_ready", 32'(f_r0.cmd_ready), 32'h0);
        tick();
        applyData(1, 8'h12, 1, 0);
        f_m.data_ready = 1'b0;
        #1;
        checkOutput("wm_b1_data", 32'(f_m.data), 32'h12);
        checkOutput("wm_b1_stall_ready", 32'(f_r1.data_ready), 32'h0);
        tick();
        f_m.data_ready = 1'b1;
        #1;
        checkOutput("wm_b1_grant", 32'(f_grant), 32'h2);
        tick();
        applyData(1, 8'h34, 1, 1);
        #1;
        checkOutput("wm_b2_grant", 32'(f_grant), 32'h2);
        checkOutput("wm_b2_last", 32'(f_m.data_last), 32'h1);
        checkOutput("wm_b2_data", 32'(f_m.data), 32'h34);
        tick();
        applyData(1, 8'h00, 0, 0);
        #1;
        checkOutput("wm_release_grant", 32'(f_grant), 32'h0);
        checkOutput("wm_release_ready", 32'(f_r1.data_ready), 32'h0);

        // r0 takes the bus with an open write, then stalls into the timeout
        tick(); #1;
        checkOutput("to_grant", 32'(f_grant), 32'h1);
        checkOutput("to_m_address", 32'(f_m.cmd_address), 32'h22);
        tick();
        applyStimulus(0, 7'h22, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("to_idle0_grant", 32'(f_grant), 32'h1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 1) applyStimulus(1, 7'h41, 1, 0, 1, 1, 1, 1);
            #1;
            checkOutput($sformatf("to_wait%0d_grant", i), 32'(f_grant), 32'h1);
            checkOutput($sformatf("to_wait%0d_pulse", i), 32'(f_timeout), 32'h0);
            checkOutput($sformatf("to_wait%0d_r1_ready", i), 32'(f_r1.cmd_ready), 32'h0);
        end
        tick(); #1;
        checkOutput("to_pulse", 32'(f_timeout), 32'h1);
        checkOutput("to_pulse_grant", 32'(f_grant), 32'h0);
        checkOutput("to_pulse_busy", 32'(f_busy), 32'h0);
        tick(); #1;
        checkOutput("to_r1_grant", 32'(f_grant), 32'h2);
        checkOutput("to_pulse_end", 32'(f_timeout), 32'h0);
        checkOutput("to_r1_wm", 32'(f_m.cmd_write_multiple), 32'h1);

        // Reset in the middle of r1's write_multiple
        tick();
        applyStimulus(1, 7'h41, 0, 0, 0, 0, 0, 0);
        applyData(1, 8'h55, 1, 0);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_grant_pre", 32'(f_grant), 32'h2);
        tick(); #1;
        checkOutput("rst_mid_grant", 32'(f_grant), 32'h0);
        checkOutput("rst_mid_busy", 32'(f_busy), 32'h0);
        checkOutput("rst_mid_timeout", 32'(f_timeout), 32'h0);
        checkOutput("rst_mid_m_data_valid", 32'(f_m.data_valid), 32'h0);
        checkOutput("rst_mid_m_cmd_valid", 32'(f_m.cmd_valid), 32'h0);
        checkOutput("rst_mid_r1_data_ready", 32'(f_r1.data_ready), 32'h0);
        checkOutput("rst_mid_r1_cmd_ready", 32'(f_r1.cmd_ready), 32'h0);
        rst = 1'b0;
        applyData(1, 8'h00, 0, 0);
        applyStimulus(1, 7'h41, 1, 0, 1, 0, 0, 1);
        tick(); #1;
        checkOutput("post_rst_grant", 32'(f_grant), 32'h2);
        tick();
        applyStimulus(1, 7'h41, 0, 0, 0, 0, 0, 0);
        applyData(1, 8'h77, 1, 1);
        #1;
        checkOutput("post_rst_last", 32'(f_m.data_last), 32'h1);
        checkOutput("post_rst_data_ready", 32'(f_r1.data_ready), 32'h1);
        tick();
        applyData(1, 8'h00, 0, 0);
        #1;
        checkOutput("post_rst_wm_cleared", 32'(f_grant), 32'h2);

        // Round-robin alternation on the second instance
        tick();
        q_r0.cmd_address = 7'h30; q_r0.cmd_start = 1; q_r0.cmd_write = 1;
        q_r0.cmd_stop = 1; q_r0.cmd_valid = 1;
        q_r1.cmd_address = 7'h31; q_r1.cmd_start = 1; q_r1.cmd_write = 1;
        q_r1.cmd_stop = 1; q_r1.cmd_valid = 1;
        #1;
        checkOutput("rr_grant_pre", 32'(q_grant), 32'h0);
        for (int i = 0; i < 7; i++) begin
            tick(); #1;
            checkOutput($sformatf("rr_grant%0d", i), 32'(q_grant), 32'(rr_exp[i]));
        end
        q_r0.cmd_valid = 0;
        q_r1.cmd_valid = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Two-requester arbiter that shares one `i2c_master` host interface (command stream plus write-data stream) between independent command sources, e.g. a power-up init sequencer and a Wishbone-driven register writer. Grants are held for a whole I2C transaction, through to the command or data beat that carries STOP, so transfers from different requesters never interleave on the bus. An optional idle timeout reclaims the bus from a stalled owner. The block sits between the requesters and `i2c_master`, in the same clock domain as that master.

## Interface
- `ROUND_ROBIN`, default 0.
  - 0: fixed priority, requester 0 wins.
  - 1: round-robin, the requester not served last wins a tie.
- `TIMEOUT`, default 0. Owner-idle cycles before a forced release. 0 disables the timeout.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rN_cmd_address` in 7 (N=0,1): requester I2C address.
- `rN_cmd_start/read/write/write_multiple/stop` in 1 each: command flags.
- `rN_cmd_valid` in 1, `rN_cmd_ready` out 1: command handshake.
- `rN_data` in 8, `rN_data_valid` in 1, `rN_data_ready` out 1, `rN_data_last` in 1: write-data stream.
- `m_cmd_address` out 7, `m_cmd_start/read/write/write_multiple/stop` out 1 each: command to `i2c_master`.
- `m_cmd_valid` out 1, `m_cmd_ready` in 1: master command handshake.
- `m_data` out 8, `m_data_valid` out 1, `m_data_ready` in 1, `m_data_last` out 1: master write-data stream.
- `grant` out 2: one-hot current owner; 00 when idle.
- `busy` out 1: high while any grant is held.
- `timeout` out 1: one-cycle pulse on forced release.

## Operation
- States:
  - IDLE: no owner. All `m_*valid`=0 and all `rN_*ready`=0.
  - OWN: owner fixed.
- IDLE -> OWN:
  - Arbitration looks only at `rN_cmd_valid`. `data_valid` alone never requests.
  - Fixed mode: r0 wins whenever r0_cmd_valid=1.
  - RR mode: on a tie, grant the requester ≠ `last_owner`. `last_owner` resets to 1, so r0 wins the first tie.
- OWN routing is combinational from registered `grant`:
  - All `m_cmd_*`, `m_data*` come from the owner. `m_cmd_valid` = owner cmd_valid; `m_data_valid` = owner data_valid.
  - Owner cmd_ready = `m_cmd_ready`; owner data_ready = `m_data_ready`.
  - Non-owner readies are forced 0.
- End of transaction (EOT), either case:
  - (a) command accepted (`m_cmd_valid&m_cmd_ready`) with stop=1 and write_multiple=0.
  - (b) data beat accepted (`m_data_valid&m_data_ready`) with `m_data_last`=1 while flag `wm_stop` is set.
- `wm_stop` handling:
  - Set when a command is accepted with write_multiple=1 and stop=1.
  - Cleared on EOT or when leaving OWN.
  - A write_multiple command with stop=0 does not set it; the lock continues.
- OWN -> IDLE on EOT, on timeout, or on reset. `last_owner` is updated to the released owner.
- Timeout, only when `TIMEOUT`>0:
  - Counter width clog2(TIMEOUT+1), saturating.
  - Cleared on grant, and on any cycle where the owner cmd_valid or data_valid is high.
  - Increments otherwise while in OWN.
  - Reaching `TIMEOUT` forces release and asserts `timeout` for 1 cycle.
  - The arbiter emits no STOP itself; recovering the bus is software/master responsibility.
- Unused master outputs while idle are driven 0.

## Timing
- Reset: state IDLE, `grant`=00, `busy`=0, `timeout`=0, all `m_*valid`=0, all `rN_*ready`=0, `last_owner`=1, `wm_stop`=0, counter=0.
- Grant latency: request seen in IDLE at cycle N -> `grant`/`busy` high and routing active at N+1. The first command can be accepted at N+1.
- Release: EOT handshake at cycle M -> `grant`=00 at M+1, with owner readies low from M+1. The earliest new grant is M+2, which leaves a 1-cycle dead slot.
- Owner cmd and data handshakes in the same cycle are both honoured. If one of them is an EOT, release still occurs at M+1.
- A non-owner may hold cmd_valid indefinitely. It sees ready=0 and is granted after the current release.
- `rst` asserted mid-OWN: IDLE next cycle, with no `timeout` pulse.
- Timeout with `TIMEOUT`=T: the owner is idle from cycle K (counter reaches 1 at K+1) -> `timeout` pulses and `grant`=00 at K+T.

## Test plan
- Single read, fixed mode:
  - Stimulus: r0 issues start+read addr 0x6A (stop=0), then read+stop.
  - Required: grant=01 one cycle after valid; both commands appear on m_cmd; grant=00 the cycle after the stop command is accepted.
- Fixed-priority tie:
  - Stimulus: r0 and r1 assert cmd_valid in the same IDLE cycle.
  - Required: r0 granted; r1_cmd_ready stays 0 until r0's EOT; r1 granted 2 cycles after r0's EOT.
- Round-robin alternation (ROUND_ROBIN=1):
  - Stimulus: both requesters issue continuous single-command stop transactions.
  - Required: grants alternate 01,10,01,10 with exactly 1 idle cycle between them.
- Write-multiple lock:
  - Stimulus: r1 sends write_multiple+stop to 0x41 followed by 3 data bytes 0x06,0x12,0x34 (last on 0x34), while r0 requests throughout.
  - Required: grant stays 10 until 0x34 is accepted, then releases.
- Timeout (TIMEOUT=8):
  - Stimulus: r0 is granted, issues start+write stop=0, then goes idle.
  - Required: timeout pulses and grant=00 exactly 8 cycles later; r1 is then grantable.
- Reset mid-transaction:
  - Stimulus: assert rst during an r1 write_multiple.
  - Required: next cycle grant=00, all valids and readies 0, wm_stop cleared, timeout=0.
